// File: rtl/touch_pkg.sv
// Shared constants, FSM state type and helpers for the touch X/Y sampler.
package touch_pkg;

  // ADS7843 control bytes: start, channel, 12-bit, differential, power-down between conversions
  localparam logic [7:0] CMD_X = 8'h90;
  localparam logic [7:0] CMD_Y = 8'hD0;

  // Frame geometry in dclk periods; data bits arrive on rising edges DATA_FIRST..DATA_LAST (1-based)
  localparam int FRAME_DCLKS  = 24;
  localparam int DATA_FIRST   = 10;
  localparam int DATA_LAST    = 21;
  localparam int FRAME_HALVES = 2 * FRAME_DCLKS;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FRAME_X = 3'd1,
    FRAME_Y = 3'd2,
    CHECK   = 3'd3,
    GAP     = 3'd4
  } state_t;

  // True when a 1-based rising-edge number falls inside the conversion data window
  function automatic logic is_data_edge(input logic [4:0] edge_num);
    return (int'(edge_num) >= DATA_FIRST) && (int'(edge_num) <= DATA_LAST);
  endfunction

endpackage

// File: rtl/touch_spi_frame.sv
// One 24-dclk SPI frame to the touch ADC: shifts an 8-bit command out on din,
// clocks 12 result bits in from dout, and pulses o_done when dclk has returned low.
module touch_spi_frame
  import touch_pkg::*;
#(
  parameter int DCLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic        i_dout,
  output logic        o_dclk,
  output logic        o_din,
  output logic        o_done,
  output logic [11:0] o_result
);

  localparam int DIV_W = (DCLK_DIV > 1) ? $clog2(DCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DCLK_DIV - 1);
  localparam logic [5:0]       HALF_LAST = 6'(FRAME_HALVES - 1);

  logic             r_active;
  logic [DIV_W-1:0] r_div_cnt;
  logic [5:0]       r_half;
  logic             r_dclk;
  logic [7:0]       r_cmd_sh;
  logic [11:0]      r_shift;
  logic             r_done;

  logic       w_tick;
  logic [4:0] w_rise_num;
  logic       w_capture;

  // A half-period ends on w_tick; when dclk is low the coming toggle is a rising edge
  assign w_tick     = r_active && (r_div_cnt == DIV_LAST);
  assign w_rise_num = r_half[5:1] + 5'd1;
  assign w_capture  = w_tick && !r_dclk && is_data_edge(w_rise_num);

  // Divider, half-period counter, command shifter (falling edges) and result shifter (rising edges)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active  <= 1'b0;
      r_div_cnt <= '0;
      r_half    <= '0;
      r_dclk    <= 1'b0;
      r_cmd_sh  <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_active) begin
        if (i_start) begin
          // Command MSB is on din from the start, a full half-period before the first rising edge
          r_active  <= 1'b1;
          r_div_cnt <= '0;
          r_half    <= '0;
          r_dclk    <= 1'b0;
          r_cmd_sh  <= i_cmd;
        end
      end else if (w_tick) begin
        r_div_cnt <= '0;
        r_dclk    <= ~r_dclk;
        if (r_dclk) begin
          // Falling edge: next command bit; zeros follow once all 8 have gone
          r_cmd_sh <= {r_cmd_sh[6:0], 1'b0};
        end else if (w_capture) begin
          r_shift <= {r_shift[10:0], i_dout};
        end
        if (r_half == HALF_LAST) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end else begin
          r_half <= r_half + 6'd1;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  assign o_dclk   = r_dclk;
  assign o_din    = r_cmd_sh[7];
  assign o_done   = r_done;
  assign o_result = r_shift;

endmodule

// File: rtl/touch_xy_sampler.sv
// Touch X/Y sampler: debounces the pen interrupt, reads X then Y from an
// ADS7843-style ADC in back-to-back frames, rejects zero readings and holds
// the top 8 bits of each axis. Optional macro TOUCH_AVG_EN averages four
// accepted pairs before each update.
module touch_xy_sampler
  import touch_pkg::*;
#(
  parameter int DCLK_DIV     = 25,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int GAP_CYC      = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       penirq_n,
  input  logic       adc_dout,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic       adc_cs_n,
  output logic [7:0] x_hold,
  output logic [7:0] y_hold,
  output logic       sample_valid,
  output logic       pen_down
);

  localparam int DEB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_pen_meta;
  logic             r_pen_sync;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_cs_n;
  logic             r_pen_down;
  logic [11:0]      r_x_raw;
  logic [11:0]      r_y_raw;
  logic [7:0]       r_x_hold;
  logic [7:0]       r_y_hold;
  logic             r_sample_valid;

  logic        w_start;
  logic [7:0]  w_cmd;
  logic        w_frame_done;
  logic [11:0] w_result;
  logic        w_deb_done;
  logic        w_gap_done;
  logic        w_accept;
  logic        w_to_idle;

  touch_spi_frame #(
    .DCLK_DIV (DCLK_DIV)
  ) u_frame (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_start),
    .i_cmd    (w_cmd),
    .i_dout   (adc_dout),
    .o_dclk   (adc_dclk),
    .o_din    (adc_din),
    .o_done   (w_frame_done),
    .o_result (w_result)
  );

  assign w_deb_done = !r_pen_sync && (r_deb_cnt == DEB_LAST);
  assign w_gap_done = (r_gap_cnt == GAP_LAST);
  assign w_accept   = (r_state == CHECK) && (r_x_raw != 12'd0) && (r_y_raw != 12'd0);
  assign w_to_idle  = (r_state == GAP) && w_gap_done && r_pen_sync;

  // Two-flop synchroniser for the asynchronous pen interrupt (idles high = not touched)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pen_meta <= 1'b1;
      r_pen_sync <= 1'b1;
    end else begin
      r_pen_meta <= penirq_n;
      r_pen_sync <= r_pen_meta;
    end
  end

  // State register plus chip select registered from the next state so it never glitches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cs_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cs_n  <= !((w_state_next == FRAME_X) || (w_state_next == FRAME_Y));
    end
  end

  // Next-state logic and frame launch; Y frame starts the clock after X finishes, cs_n stays low
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_cmd        = CMD_X;
    case (r_state)
      IDLE: begin
        if (w_deb_done) begin
          w_state_next = FRAME_X;
          w_start      = 1'b1;
        end
      end
      FRAME_X: begin
        if (w_frame_done) begin
          w_state_next = FRAME_Y;
          w_start      = 1'b1;
          w_cmd        = CMD_Y;
        end
      end
      FRAME_Y: begin
        if (w_frame_done) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        w_state_next = GAP;
      end
      GAP: begin
        if (w_gap_done) begin
          if (!r_pen_sync) begin
            w_state_next = FRAME_X;
            w_start      = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Debounce and gap timers; a high pen sample in IDLE restarts the debounce count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_deb_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && !r_pen_sync && !w_deb_done) begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end else begin
        r_deb_cnt <= '0;
      end
      if ((r_state == GAP) && !w_gap_done) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  // Debounced pen status and raw conversion capture at the end of each frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pen_down <= 1'b0;
      r_x_raw    <= '0;
      r_y_raw    <= '0;
    end else begin
      if ((r_state == IDLE) && w_deb_done) begin
        r_pen_down <= 1'b1;
      end else if (w_to_idle) begin
        r_pen_down <= 1'b0;
      end
      if ((r_state == FRAME_X) && w_frame_done) begin
        r_x_raw <= w_result;
      end
      if ((r_state == FRAME_Y) && w_frame_done) begin
        r_y_raw <= w_result;
      end
    end
  end

`ifdef TOUCH_AVG_EN
  logic [13:0] r_sum_x;
  logic [13:0] r_sum_y;
  logic [1:0]  r_avg_cnt;
  logic [13:0] w_sum_x_total;
  logic [13:0] w_sum_y_total;

  assign w_sum_x_total = r_sum_x + {2'b00, r_x_raw};
  assign w_sum_y_total = r_sum_y + {2'b00, r_y_raw};

  // Accumulate accepted pairs; every fourth one publishes the averaged top byte and clears
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum_x        <= '0;
      r_sum_y        <= '0;
      r_avg_cnt      <= '0;
      r_x_hold       <= '0;
      r_y_hold       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_to_idle) begin
        r_sum_x   <= '0;
        r_sum_y   <= '0;
        r_avg_cnt <= '0;
      end else if (w_accept) begin
        if (r_avg_cnt == 2'd3) begin
          r_x_hold       <= w_sum_x_total[13:6];
          r_y_hold       <= w_sum_y_total[13:6];
          r_sample_valid <= 1'b1;
          r_sum_x        <= '0;
          r_sum_y        <= '0;
          r_avg_cnt      <= '0;
        end else begin
          r_sum_x   <= w_sum_x_total;
          r_sum_y   <= w_sum_y_total;
          r_avg_cnt <= r_avg_cnt + 2'd1;
        end
      end
    end
  end
`else
  // Every accepted pair updates both bytes together with a one-clock valid pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_hold       <= '0;
      r_y_hold       <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      if (w_accept) begin
        r_x_hold       <= r_x_raw[11:4];
        r_y_hold       <= r_y_raw[11:4];
        r_sample_valid <= 1'b1;
      end
    end
  end
`endif

  assign adc_cs_n     = r_cs_n;
  assign x_hold       = r_x_hold;
  assign y_hold       = r_y_hold;
  assign sample_valid = r_sample_valid;
  assign pen_down     = r_pen_down;

endmodule
